// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM->WB pipeline register with data-memory handshake tracking
// and load formatting for the rv32i 5-stage pipeline.
//
// Latency: one cycle from MEM inputs to the registered WB outputs. mem_stall_req
// is combinational, so a data_resp arriving in the same cycle does not stall.
//
// Backpressure: while a data access is outstanding, mem_stall_req freezes IF..MEM
// and a bubble is loaded into WB. stall_in (external) holds the WB register.
// A response that arrives during an external stall is latched, so the access is
// not re-requested and the instruction advances on release using the latched word.
//
// Optional build macro MEM_WB_PERF_EN adds the performance counters
// perf_retired, perf_loads and perf_mem_stall_cycles.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   stall_in, flush_in   external freeze of WB / squash into a WB bubble
//   mem_*_in, funct3_in, wb_sel_in, load_regfile_in, rd_in, alu_out_in,
//   pc_in, br_en_in      MEM-stage instruction fields
//   data_rdata, data_resp  dcache read word and one-cycle response pulse
//   mem_stall_req        access outstanding, freeze IF..MEM
//   wb_valid, wb_load_regfile, wb_rd, wb_data  registered WB / regfile controls
module mem_wb_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_in,
  input  logic                  flush_in,
  input  logic                  mem_valid_in,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic [2:0]            funct3_in,
  input  logic [1:0]            wb_sel_in,
  input  logic                  load_regfile_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic [XLEN-1:0]       alu_out_in,
  input  logic [XLEN-1:0]       pc_in,
  input  logic                  br_en_in,
  input  logic [XLEN-1:0]       data_rdata,
  input  logic                  data_resp,
  output logic                  mem_stall_req,
  output logic                  wb_valid,
  output logic                  wb_load_regfile,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [XLEN-1:0]       wb_data
`ifdef MEM_WB_PERF_EN
  ,
  output logic [63:0]           perf_retired,
  output logic [31:0]           perf_loads,
  output logic [31:0]           perf_mem_stall_cycles
`endif
);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] SEL_ALU  = 2'd0;
  localparam logic [1:0] SEL_LOAD = 2'd1;
  localparam logic [1:0] SEL_PC4  = 2'd2;

  // Handshake tracking
  logic mem_acc;
  logic pending;
  logic adv;

  logic            done_q, done_d;
  logic [XLEN-1:0] rdata_q, rdata_d;

  // WB register
  logic                  wb_valid_q, wb_valid_d;
  logic                  wb_lr_q, wb_lr_d;
  logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]       wb_data_q, wb_data_d;

  // Load formatting
  logic [XLEN-1:0] ld_word;
  logic [1:0]      off;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_val;
  logic [XLEN-1:0] sel_val;

  assign mem_acc       = mem_valid_in & (mem_read_in | mem_write_in);
  // done_q masks an access whose response already arrived during an external stall.
  assign pending       = mem_acc & ~done_q;
  assign mem_stall_req = pending & ~data_resp;
  assign adv           = ~stall_in & ~mem_stall_req;

  // ---------------------------------------------------------------------------
  // Response tracking
  // ---------------------------------------------------------------------------
  always_comb begin
    done_d = done_q;
    if (flush_in) begin
      done_d = 1'b0;
    end else if (adv) begin
      done_d = 1'b0;
    end else if (data_resp && stall_in && mem_acc) begin
      // Only a response for the instruction actually held in MEM is remembered;
      // a stray pulse with no access in MEM must not pre-complete the next one.
      done_d = 1'b1;
    end
  end

  assign rdata_d = data_resp ? data_rdata : rdata_q;

  // ---------------------------------------------------------------------------
  // Load extraction and writeback select
  // ---------------------------------------------------------------------------
  // Same-cycle response bypasses the latch so the zero-stall path uses fresh data.
  assign ld_word = data_resp ? data_rdata : rdata_q;
  assign off     = alu_out_in[1:0];

  always_comb begin
    ld_byte = ld_word[7:0];
    case (off)
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
  end

  // Misaligned halfwords are not trapped: off[1] alone picks the lane.
  assign ld_half = off[1] ? ld_word[31:16] : ld_word[15:0];

  always_comb begin
    ld_val = ld_word;
    case (funct3_in)
      F3_LB:   ld_val = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      F3_LH:   ld_val = {{(XLEN-16){ld_half[15]}}, ld_half};
      F3_LBU:  ld_val = {{(XLEN-8){1'b0}}, ld_byte};
      F3_LHU:  ld_val = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_val = ld_word;
    endcase
  end

  always_comb begin
    sel_val = alu_out_in;
    case (wb_sel_in)
      SEL_ALU:  sel_val = alu_out_in;
      SEL_LOAD: sel_val = ld_val;
      SEL_PC4:  sel_val = pc_in + XLEN'(4);
      default:  sel_val = {{(XLEN-1){1'b0}}, br_en_in};
    endcase
  end

  // ---------------------------------------------------------------------------
  // WB register next state (reset applied in the register process)
  // ---------------------------------------------------------------------------
  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_lr_d    = wb_lr_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    if (flush_in) begin
      wb_valid_d = 1'b0;
      wb_lr_d    = 1'b0;
    end else if (stall_in) begin
      // hold everything
    end else if (mem_stall_req) begin
      wb_valid_d = 1'b0;
      wb_lr_d    = 1'b0;
    end else begin
      wb_valid_d = mem_valid_in;
      // x0 is never written, so drop the enable here rather than in the regfile
      // and keep the forwarding unit from matching on rd=0.
      wb_lr_d    = mem_valid_in & load_regfile_in & (rd_in != '0);
      wb_rd_d    = rd_in;
      wb_data_d  = sel_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q     <= 1'b0;
      rdata_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_lr_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      done_q     <= done_d;
      rdata_q    <= rdata_d;
      wb_valid_q <= wb_valid_d;
      wb_lr_q    <= wb_lr_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign wb_valid        = wb_valid_q;
  assign wb_load_regfile = wb_lr_q;
  assign wb_rd           = wb_rd_q;
  assign wb_data         = wb_data_q;

`ifdef MEM_WB_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters (free-running, wrap on overflow)
  // ---------------------------------------------------------------------------
  logic [63:0] retired_q, retired_d;
  logic [31:0] loads_q, loads_d;
  logic [31:0] mstall_q, mstall_d;
  logic        retire_now;

  // A retirement is a WB load from the advance path carrying a valid instruction.
  assign retire_now = ~flush_in & adv & mem_valid_in;

  always_comb begin
    retired_d = retired_q;
    loads_d   = loads_q;
    mstall_d  = mstall_q;
    if (retire_now) begin
      retired_d = retired_q + 64'd1;
      if (mem_read_in) begin
        loads_d = loads_q + 32'd1;
      end
    end
    if (mem_stall_req) begin
      mstall_d = mstall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
      loads_q   <= '0;
      mstall_q  <= '0;
    end else begin
      retired_q <= retired_d;
      loads_q   <= loads_d;
      mstall_q  <= mstall_d;
    end
  end

  assign perf_retired          = retired_q;
  assign perf_loads            = loads_q;
  assign perf_mem_stall_cycles = mstall_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: the driver plays hazard unit and dcache,
// pushes the expected WB result for every instruction that should retire, and
// an independent monitor pops and compares whenever WB is freshly loaded.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst;
  logic        stall_in, flush_in;
  logic        mem_valid_in, mem_read_in, mem_write_in;
  logic [2:0]  funct3_in;
  logic [1:0]  wb_sel_in;
  logic        load_regfile_in;
  logic [4:0]  rd_in;
  logic [31:0] alu_out_in, pc_in;
  logic        br_en_in;
  logic [31:0] data_rdata;
  logic        data_resp;
  logic        mem_stall_req, wb_valid, wb_load_regfile;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
`ifdef MEM_WB_PERF_EN
  logic [63:0] perf_retired;
  logic [31:0] perf_loads, perf_mem_stall_cycles;
`endif

  mem_wb_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .flush_in(flush_in),
    .mem_valid_in(mem_valid_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .funct3_in(funct3_in), .wb_sel_in(wb_sel_in), .load_regfile_in(load_regfile_in),
    .rd_in(rd_in), .alu_out_in(alu_out_in), .pc_in(pc_in), .br_en_in(br_en_in),
    .data_rdata(data_rdata), .data_resp(data_resp), .mem_stall_req(mem_stall_req),
    .wb_valid(wb_valid), .wb_load_regfile(wb_load_regfile), .wb_rd(wb_rd), .wb_data(wb_data)
`ifdef MEM_WB_PERF_EN
    , .perf_retired(perf_retired), .perf_loads(perf_loads),
    .perf_mem_stall_cycles(perf_mem_stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld, rd_op, wr_op, lr, br;
    logic [2:0]  f3;
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic [31:0] alu, pc, rdata;
    logic [15:0] stall_mask;  // bit i: stall_in during i-th cycle in MEM
    int          resp_dly;    // dcache answers in this cycle (counted from entry)
    int          flush_at;    // cycle at which the instruction is squashed, -1 none
  } txn_t;

  typedef struct {
    logic [4:0]  rd;
    logic        lr;
    logic [31:0] data;
    logic        chkd;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int checks = 0;
  int failures = 0;

  logic cap_rst = 1'b1, cap_stall = 1'b0, cap_flush = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference writeback value, straight from the ISA load rules.
  function automatic logic [31:0] ref_wb(input txn_t t);
    int unsigned w, off, b, h, r;
    w   = t.rdata;
    off = t.alu & 32'd3;
    b   = (w >> (8 * off)) & 32'hFF;
    h   = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (t.sel)
      2'd0: r = t.alu;
      2'd2: r = t.pc + 32'd4;
      2'd3: r = t.br ? 32'd1 : 32'd0;
      default: begin
        case (t.f3)
          3'd0:    r = (b >= 128) ? b + 32'hFFFF_FF00 : b;
          3'd1:    r = (h >= 32768) ? h + 32'hFFFF_0000 : h;
          3'd4:    r = b;
          3'd5:    r = h;
          default: r = w;
        endcase
      end
    endcase
    return r;
  endfunction

  function automatic txn_t blank();
    txn_t t;
    t.vld = 1'b1; t.rd_op = 1'b0; t.wr_op = 1'b0; t.lr = 1'b1; t.br = 1'b0;
    t.f3 = 3'd2; t.sel = 2'd0; t.rd = 5'd1;
    t.alu = 32'h0; t.pc = 32'h100; t.rdata = 32'h0;
    t.stall_mask = 16'h0; t.resp_dly = 0; t.flush_at = -1;
    return t;
  endfunction

  task automatic drive(input txn_t t, input logic st, input logic fl, input logic resp);
    stall_in = st; flush_in = fl;
    mem_valid_in = t.vld; mem_read_in = t.rd_op; mem_write_in = t.wr_op;
    funct3_in = t.f3; wb_sel_in = t.sel; load_regfile_in = t.lr; rd_in = t.rd;
    alu_out_in = t.alu; pc_in = t.pc; br_en_in = t.br;
    data_resp = resp;
    data_rdata = resp ? t.rdata : $urandom;
  endtask

  task automatic push_exp(input txn_t t);
    exp_t e;
    e.rd   = t.rd;
    e.lr   = t.lr && (t.rd != 5'd0);
    e.data = ref_wb(t);
    e.chkd = !(t.wr_op && !t.lr);
    exp_q.push_back(e);
  endtask

  // Holds one instruction in MEM until it retires or is squashed.
  task automatic run_txn(input txn_t t);
    bit is_mem, got, done, st, fl, resp_now, exp_stall;
    int cyc;
    is_mem = t.vld && (t.rd_op || t.wr_op);
    got = 0; done = 0; cyc = 0;
    while (!done) begin
      st        = (cyc < 16) ? t.stall_mask[cyc] : 1'b0;
      fl        = (cyc == t.flush_at);
      resp_now  = is_mem && !got && (cyc == t.resp_dly);
      exp_stall = is_mem && !got && !resp_now;
      drive(t, st, fl, resp_now);
      @(negedge clk);
      chk($sformatf("mem_stall_req cyc%0d", cyc), 32'(mem_stall_req), 32'(exp_stall));
      if (fl) done = 1;
      else if (st) begin
        if (resp_now) got = 1;
      end else if (!exp_stall) begin
        done = 1;
        if (t.vld) push_exp(t);
      end
      cyc++;
      if (!done && cyc >= 64) begin
        checks++; failures++;
        $display("FAIL txn_timeout: instruction still in MEM after %0d cycles, required retire", cyc);
        done = 1;
      end
      @(posedge clk); #1;
    end
  endtask

  // Monitor: WB was freshly loaded at the last edge unless reset, stall or flush.
  always @(posedge clk) begin
    cap_rst   <= rst;
    cap_stall <= stall_in;
    cap_flush <= flush_in;
  end

  always @(negedge clk) begin
    if (!cap_rst) begin
      if (cap_flush) begin
        chk("flush_wb_valid", 32'(wb_valid), 32'd0);
        chk("flush_wb_load_regfile", 32'(wb_load_regfile), 32'd0);
      end else if (!cap_stall && wb_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL wb_unexpected: got valid rd=%0d data=%08h, required no retirement", wb_rd, wb_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (wb_rd !== mon_e.rd || wb_load_regfile !== mon_e.lr ||
              (mon_e.chkd && wb_data !== mon_e.data)) begin
            failures++;
            $display("FAIL wb_out: got rd=%0d lr=%0b data=%08h, required rd=%0d lr=%0b data=%08h",
                     wb_rd, wb_load_regfile, wb_data, mon_e.rd, mon_e.lr, mon_e.data);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t;
    int r;
    rst = 1'b1;
    drive(blank(), 1'b0, 1'b0, 1'b0);
    mem_valid_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_load_regfile", 32'(wb_load_regfile), 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // lb, byte 3 of 0x80FF1234 = 0x80 -> sign extended
    t = blank(); t.rd_op = 1; t.f3 = 3'd0; t.sel = 2'd1; t.rd = 5'd5;
    t.alu = 32'h1003; t.rdata = 32'h80FF_1234; t.resp_dly = 0;
    run_txn(t);
    // lhu, upper half, response after 3 stall cycles
    t = blank(); t.rd_op = 1; t.f3 = 3'd5; t.sel = 2'd1; t.rd = 5'd6;
    t.alu = 32'h2002; t.rdata = 32'h8001_7FFF; t.resp_dly = 3;
    run_txn(t);
    // lw answered during external stall, data bus changes afterwards
    t = blank(); t.rd_op = 1; t.f3 = 3'd2; t.sel = 2'd1; t.rd = 5'd7;
    t.alu = 32'h3000; t.rdata = 32'hDEAD_BEEF; t.resp_dly = 1; t.stall_mask = 16'h0007;
    run_txn(t);
    // ALU op to x0, then pc+4 wraparound
    t = blank(); t.rd = 5'd0; t.alu = 32'd5; t.sel = 2'd0;
    run_txn(t);
    t = blank(); t.rd = 5'd3; t.sel = 2'd2; t.pc = 32'hFFFF_FFFC;
    run_txn(t);
    // flush coinciding with response, next load must request again
    t = blank(); t.rd_op = 1; t.sel = 2'd1; t.rd = 5'd8; t.rdata = 32'h1234_5678;
    t.resp_dly = 0; t.flush_at = 0;
    run_txn(t);
    t = blank(); t.rd_op = 1; t.f3 = 3'd1; t.sel = 2'd1; t.rd = 5'd9;
    t.alu = 32'h0002; t.rdata = 32'hFF80_0000; t.resp_dly = 2;
    run_txn(t);
    // response latched during stall, then flushed: the latch must not carry over
    t = blank(); t.wr_op = 1; t.lr = 0; t.resp_dly = 0; t.stall_mask = 16'h0003; t.flush_at = 1;
    run_txn(t);
    t = blank(); t.rd_op = 1; t.f3 = 3'd4; t.sel = 2'd1; t.rd = 5'd10;
    t.alu = 32'h0001; t.rdata = 32'h0000_9A00; t.resp_dly = 1;
    run_txn(t);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      t = blank();
      r = $urandom_range(0, 99);
      t.vld   = ($urandom_range(0, 9) != 0);
      t.rd    = 5'($urandom);
      t.alu   = $urandom;
      t.pc    = $urandom;
      t.br    = 1'($urandom);
      t.rdata = $urandom;
      t.f3    = 3'($urandom);
      t.lr    = ($urandom_range(0, 3) != 0);
      if (r < 40) begin
        t.rd_op = 1; t.sel = 2'd1;
      end else if (r < 55) begin
        t.wr_op = 1; t.lr = 0; t.sel = 2'($urandom);
      end else begin
        r = $urandom_range(0, 2);
        t.sel = (r == 0) ? 2'd0 : (r == 1) ? 2'd2 : 2'd3;
      end
      if (!t.vld) begin
        t.rd_op = 1'($urandom); t.wr_op = 1'($urandom);
      end
      t.stall_mask = 16'($urandom & $urandom);
      t.resp_dly   = $urandom_range(0, 4);
      t.flush_at   = ($urandom_range(0, 11) == 0) ? $urandom_range(0, 3) : -1;
      run_txn(t);
    end

    // Reset in the middle of a stalled access whose response was already latched
    t = blank(); t.rd = 5'd7; t.alu = 32'h0000_1234;
    run_txn(t);
    t = blank(); t.rd_op = 1; t.sel = 2'd1; t.rd = 5'd9; t.rdata = 32'h1111_2222;
    drive(t, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("resp_in_stall_no_req", 32'(mem_stall_req), 32'd0);
    @(posedge clk); #1;
    drive(t, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("latched_no_rerequest", 32'(mem_stall_req), 32'd0);
    chk("stall_holds_wb_rd", 32'(wb_rd), 32'd7);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(t, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("midrst_wb_valid", 32'(wb_valid), 32'd0);
    chk("midrst_wb_load_regfile", 32'(wb_load_regfile), 32'd0);
    chk("midrst_wb_rd", 32'(wb_rd), 32'd0);
    chk("midrst_wb_data", wb_data, 32'd0);
    chk("midrst_rerequest", 32'(mem_stall_req), 32'd1);
`ifdef MEM_WB_PERF_EN
    chk("midrst_perf_retired_lo", perf_retired[31:0], 32'd0);
    chk("midrst_perf_loads", perf_loads, 32'd0);
`endif
    @(posedge clk); #1;
    t.rdata = 32'hCAFE_F00D; t.resp_dly = 0;
    run_txn(t);

    // Drain
    t = blank(); t.vld = 1'b0;
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) run_txn(t);
    run_txn(t);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
